// File: rtl/lif_array.sv
// lif_array: time-multiplexed array of leaky integrate-and-fire neurons.
//
// Each neuron keeps its own membrane potential, adaptive threshold and
// refractory counter. One current sample, tagged with a neuron index, is
// accepted per valid/ready handshake. The update result is registered and
// presented one cycle later on the output handshake.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  input handshake (in_ready is combinational)
//   in_idx             neuron addressed by the sample
//   in_current         unsigned input current
//   learn_en           enables threshold adaptation for this sample
//   out_valid/ready    output handshake
//   out_idx            neuron that was updated
//   out_state          membrane value after the update
//   out_spike          neuron fired on this update
//   spike_cnt          saturating count of spikes since reset
module lif_array #(
  parameter int unsigned N_NEURONS    = 4,
  parameter int unsigned W            = 8,
  parameter int unsigned LEAK_SHIFT   = 3,
  parameter int unsigned TH_INIT      = 100,
  parameter int unsigned TH_MAX       = 220,
  parameter int unsigned TH_MIN       = 8,
  parameter int unsigned TH_INC_SHIFT = 3,
  parameter int unsigned TH_DEC_SHIFT = 4,
  parameter int unsigned REFRAC       = 2,
  localparam int unsigned IW          = $clog2(N_NEURONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_idx,
  input  logic [W-1:0]  in_current,
  input  logic          learn_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [W-1:0]  out_state,
  output logic          out_spike,
  output logic [15:0]   spike_cnt
);

  // Refractory counter width; kept at least one bit when REFRAC is 0.
  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int unsigned CW = 16;

  typedef logic [W-1:0] word_t;
  typedef logic [W:0]   wide_t;

  // Per-neuron storage
  word_t         state_q  [N_NEURONS];
  word_t         state_d  [N_NEURONS];
  word_t         th_q     [N_NEURONS];
  word_t         th_d     [N_NEURONS];
  logic [RW-1:0] refrac_q [N_NEURONS];
  logic [RW-1:0] refrac_d [N_NEURONS];

  // Output registers
  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_idx_q,   out_idx_d;
  word_t         out_state_q, out_state_d;
  logic          out_spike_q, out_spike_d;
  logic [CW-1:0] spike_cnt_q, spike_cnt_d;

  // Datapath for the addressed neuron
  word_t         sel_state;
  word_t         sel_th;
  logic [RW-1:0] sel_refrac;
  logic          in_refrac;
  wide_t         v_wide;
  word_t         v_sat;
  logic          fire;
  wide_t         th_up_wide;
  wide_t         th_dn_wide;
  word_t         th_up;
  word_t         th_dn;
  logic          accept;

  // A new sample may enter whenever the output slot is empty or draining.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_state = out_state_q;
  assign out_spike = out_spike_q;
  assign spike_cnt = spike_cnt_q;

  // Leak, integrate, saturate, fire decision and threshold candidates.
  // Reads come straight from the registers, so a back-to-back update to
  // the same neuron sees the value written on the previous edge.
  always_comb begin
    sel_state  = state_q[in_idx];
    sel_th     = th_q[in_idx];
    sel_refrac = refrac_q[in_idx];
    in_refrac  = (sel_refrac != '0);

    // state - leak never underflows; the extra bit catches the add carry.
    v_wide = wide_t'(sel_state) - wide_t'(sel_state >> LEAK_SHIFT)
           + wide_t'(in_current);
    v_sat  = v_wide[W] ? '1 : v_wide[W-1:0];
    fire   = !in_refrac && (v_sat >= sel_th);

    th_up_wide = wide_t'(sel_th) + wide_t'(sel_th >> TH_INC_SHIFT);
    th_up      = (th_up_wide > wide_t'(TH_MAX)) ? word_t'(TH_MAX)
                                                : th_up_wide[W-1:0];
    th_dn_wide = wide_t'(sel_th) - wide_t'(sel_th >> TH_DEC_SHIFT);
    th_dn      = (th_dn_wide < wide_t'(TH_MIN)) ? word_t'(TH_MIN)
                                                : th_dn_wide[W-1:0];
  end

  // Next-state for neuron storage, output slot and spike counter.
  always_comb begin
    for (int i = 0; i < int'(N_NEURONS); i++) begin
      state_d[i]  = state_q[i];
      th_d[i]     = th_q[i];
      refrac_d[i] = refrac_q[i];
    end
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_state_d = out_state_q;
    out_spike_d = out_spike_q;
    spike_cnt_d = spike_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_idx_d   = in_idx;
      if (in_refrac) begin
        // Refractory: current is discarded, threshold left alone.
        refrac_d[in_idx] = sel_refrac - RW'(1);
        state_d[in_idx]  = '0;
        out_state_d      = '0;
        out_spike_d      = 1'b0;
      end else if (fire) begin
        state_d[in_idx]  = '0;
        refrac_d[in_idx] = RW'(REFRAC);
        out_state_d      = '0;
        out_spike_d      = 1'b1;
        if (spike_cnt_q != '1) begin
          spike_cnt_d = spike_cnt_q + CW'(1);
        end
        if (learn_en) begin
          th_d[in_idx] = th_up;
        end
      end else begin
        state_d[in_idx] = v_sat;
        out_state_d     = v_sat;
        out_spike_d     = 1'b0;
        if (learn_en) begin
          th_d[in_idx] = th_dn;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        state_q[i]  <= '0;
        th_q[i]     <= word_t'(TH_INIT);
        refrac_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_state_q <= '0;
      out_spike_q <= 1'b0;
      spike_cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        state_q[i]  <= state_d[i];
        th_q[i]     <= th_d[i];
        refrac_q[i] <= refrac_d[i];
      end
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_state_q <= out_state_d;
      out_spike_q <= out_spike_d;
      spike_cnt_q <= spike_cnt_d;
    end
  end

endmodule

// File: tb/tb_lif_array.sv
// tb_lif_array: directed self-checking bench for lif_array with default
// parameters (4 neurons, 8-bit, leak >>3, th 100 in [8,220], refrac 2).
module tb_lif_array;

  localparam int unsigned W  = 8;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  cur;
    logic          learn;
    logic [W-1:0]  st;
    logic          sp;
  } step_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_idx;
  logic [W-1:0]  in_current;
  logic          learn_en;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic [W-1:0]  out_state;
  logic          out_spike;
  logic [15:0]   spike_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  logic          obs_valid;
  logic [IW-1:0] obs_idx;
  logic [W-1:0]  obs_state;
  logic          obs_spike;

  lif_array dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_current (in_current),
    .learn_en   (learn_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_state  (out_state),
    .out_spike  (out_spike),
    .spike_cnt  (spike_cnt)
  );

  always #5 clk = ~clk;

  function automatic step_t stp(int idx, int cur, bit learn, int st, bit sp);
    return '{IW'(idx), W'(cur), learn, W'(st), sp};
  endfunction

  // One accepted sample; result captured 1 time unit after the edge.
  task automatic send(input logic [IW-1:0] idx, input logic [W-1:0] cur,
                      input logic learn);
    @(negedge clk);
    in_valid   = 1'b1;
    in_idx     = idx;
    in_current = cur;
    learn_en   = learn;
    @(posedge clk);
    #1;
    obs_valid  = out_valid;
    obs_idx    = out_idx;
    obs_state  = out_state;
    obs_spike  = out_spike;
    in_valid   = 1'b0;
    in_current = '0;
    learn_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; in_current = '0;
    learn_en = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || spike_cnt !== 16'd0 || out_state !== 8'd0 ||
        out_idx !== 2'd0 || out_spike !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: got valid=%0b cnt=%0d state=%0d idx=%0d spike=%0b rdy=%0b, want 0 0 0 0 0 1",
               out_valid, spike_cnt, out_state, out_idx, out_spike, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_accept();
    @(negedge clk);
    in_valid = 1'b1; in_idx = 2'd3; in_current = 8'd0; learn_en = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_pre_edge: got out_valid=%0b, want 0", out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 2'd3 || out_state !== 8'd0 || out_spike !== 1'b0) begin
      n_fail++;
      $display("FAIL first_result: got valid=%0b idx=%0d state=%0d spike=%0b, want 1 3 0 0",
               out_valid, out_idx, out_state, out_spike);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_drain: got out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_leak_fire_refrac();
    step_t q[$];
    q.push_back(stp(0, 40, 0, 40, 0));
    q.push_back(stp(0, 40, 0, 75, 0));
    q.push_back(stp(0, 40, 0, 0, 1));
    q.push_back(stp(0, 40, 0, 0, 0));
    q.push_back(stp(0, 40, 0, 0, 0));
    q.push_back(stp(0, 40, 0, 40, 0));
    q.push_back(stp(0, 40, 0, 75, 0));
    for (int k = 0; k < q.size(); k++) begin
      send(q[k].idx, q[k].cur, q[k].learn);
      if (q[k].sp) exp_cnt++;
      n_checks++;
      if (obs_valid !== 1'b1 || obs_idx !== q[k].idx || obs_state !== q[k].st ||
          obs_spike !== q[k].sp) begin
        n_fail++;
        $display("FAIL leak_fire[%0d]: got valid=%0b idx=%0d state=%0d spike=%0b, want 1 %0d %0d %0b",
                 k, obs_valid, obs_idx, obs_state, obs_spike, q[k].idx, q[k].st, q[k].sp);
      end
    end
    n_checks++;
    if (spike_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL leak_fire_cnt: got %0d, want %0d", spike_cnt, exp_cnt);
    end
  endtask

  task automatic test_sat_interleave();
    step_t q[$];
    q.push_back(stp(2, 99, 0, 99, 0));
    q.push_back(stp(0, 0, 0, 66, 0));
    q.push_back(stp(2, 0, 0, 87, 0));
    q.push_back(stp(2, 255, 0, 0, 1));
    for (int k = 0; k < q.size(); k++) begin
      send(q[k].idx, q[k].cur, q[k].learn);
      if (q[k].sp) exp_cnt++;
      n_checks++;
      if (obs_valid !== 1'b1 || obs_idx !== q[k].idx || obs_state !== q[k].st ||
          obs_spike !== q[k].sp) begin
        n_fail++;
        $display("FAIL sat_interleave[%0d]: got valid=%0b idx=%0d state=%0d spike=%0b, want 1 %0d %0d %0b",
                 k, obs_valid, obs_idx, obs_state, obs_spike, q[k].idx, q[k].st, q[k].sp);
      end
    end
    n_checks++;
    if (spike_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL sat_cnt: got %0d, want %0d", spike_cnt, exp_cnt);
    end
  endtask

  task automatic test_learn();
    step_t q[$];
    // Neuron 1: threshold decays 100 -> 94, then v=95 fires.
    q.push_back(stp(1, 0, 1, 0, 0));
    q.push_back(stp(1, 95, 0, 0, 1));
    q.push_back(stp(1, 0, 0, 0, 0));
    q.push_back(stp(1, 0, 0, 0, 0));
    // Nine learning spikes: 94,105,118,132,148,166,186,209 -> 220 (clamped).
    for (int s = 0; s < 9; s++) begin
      q.push_back(stp(1, 255, 1, 0, 1));
      q.push_back(stp(1, 255, 1, 0, 0));
      q.push_back(stp(1, 255, 1, 0, 0));
    end
    q.push_back(stp(1, 219, 0, 219, 0));
    q.push_back(stp(1, 28, 0, 0, 1));
    // Neuron 3: spike at th=100 raises it to 112.
    q.push_back(stp(3, 100, 1, 0, 1));
    q.push_back(stp(3, 0, 0, 0, 0));
    q.push_back(stp(3, 0, 0, 0, 0));
    q.push_back(stp(3, 111, 0, 111, 0));
    q.push_back(stp(3, 15, 0, 0, 1));
    for (int k = 0; k < q.size(); k++) begin
      send(q[k].idx, q[k].cur, q[k].learn);
      if (q[k].sp) exp_cnt++;
      n_checks++;
      if (obs_valid !== 1'b1 || obs_idx !== q[k].idx || obs_state !== q[k].st ||
          obs_spike !== q[k].sp) begin
        n_fail++;
        $display("FAIL learn[%0d]: got valid=%0b idx=%0d state=%0d spike=%0b, want 1 %0d %0d %0b",
                 k, obs_valid, obs_idx, obs_state, obs_spike, q[k].idx, q[k].st, q[k].sp);
      end
    end
    n_checks++;
    if (spike_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL learn_cnt: got %0d, want %0d", spike_cnt, exp_cnt);
    end
  endtask

  task automatic test_hold();
    // Neuron 0 is at 66: 66-8+10 = 68, then after release 68-8+20 = 80.
    @(negedge clk);
    in_valid = 1'b1; in_idx = 2'd0; in_current = 8'd10; learn_en = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready  = 1'b0;
    in_current = 8'd20;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 2'd0 ||
          out_state !== 8'd68 || out_spike !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: got rdy=%0b valid=%0b idx=%0d state=%0d spike=%0b, want 0 1 0 68 0",
                 c, in_ready, out_valid, out_idx, out_state, out_spike);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release_ready: got %0b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_state !== 8'd80 || out_spike !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release_result: got valid=%0b idx=%0d state=%0d spike=%0b, want 1 0 80 0",
               out_valid, out_idx, out_state, out_spike);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drain: got out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_refrac();
    // 80-10+40 = 110 >= 100 fires; next update is refractory.
    send(2'd0, 8'd40, 1'b0);
    n_checks++;
    if (obs_spike !== 1'b1 || obs_state !== 8'd0 || spike_cnt !== 16'(exp_cnt + 1)) begin
      n_fail++;
      $display("FAIL pre_reset_fire: got spike=%0b state=%0d cnt=%0d, want 1 0 %0d",
               obs_spike, obs_state, spike_cnt, exp_cnt + 1);
    end
    send(2'd0, 8'd40, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || spike_cnt !== 16'd0 || out_state !== 8'd0 || out_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%0b cnt=%0d state=%0d idx=%0d, want 0 0 0 0",
               out_valid, spike_cnt, out_state, out_idx);
    end
    rst_n   = 1'b1;
    exp_cnt = 0;
    send(2'd0, 8'd40, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b1 || obs_idx !== 2'd0 || obs_state !== 8'd40 || obs_spike !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_refrac: got valid=%0b idx=%0d state=%0d spike=%0b, want 1 0 40 0",
               obs_valid, obs_idx, obs_state, obs_spike);
    end
    // Neuron 1 threshold was 220; after reset 100 fires on v=100.
    send(2'd1, 8'd100, 1'b0);
    exp_cnt++;
    n_checks++;
    if (obs_spike !== 1'b1 || obs_state !== 8'd0 || spike_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL post_reset_th: got spike=%0b state=%0d cnt=%0d, want 1 0 %0d",
               obs_spike, obs_state, spike_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_accept();
    test_leak_fire_refrac();
    test_sat_interleave();
    test_learn();
    test_hold();
    test_reset_mid_refrac();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
